// File: rtl/muldiv_seq.sv
// Sequencing front-end for the RISC-V M-extension: handshakes one op at a time,
// drives an external combinational multiplier and runs a radix-2 restoring divider.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_func3,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic            flush,
    input  logic            out_stall,
    output logic            mul_valid,
    output logic [2:0]      mul_op,
    output logic [XLEN-1:0] mul_op1,
    output logic [XLEN-1:0] mul_op2,
    input  logic [XLEN-1:0] mul_res,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            is_signed;
    logic            op1_neg, op2_neg;
    logic            div_zero, div_ovf;
    logic [XLEN:0]   rem_sh, rem_new;
    logic [XLEN-1:0] quo_sh;
    logic            qbit;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // The quotient register doubles as the dividend: its MSB feeds the remainder
    // while the new quotient bit enters at the LSB.
    always_comb begin
        rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        qbit    = (rem_sh >= {1'b0, dvs_q});
        rem_new = qbit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_sh  = {quo_q[XLEN-2:0], qbit};
        quo_fix = qneg_q ? (~quo_sh + 1'b1) : quo_sh;
        rem_fix = rneg_q ? (~rem_new[XLEN-1:0] + 1'b1) : rem_new[XLEN-1:0];
    end

    always_comb begin
        is_signed = ~in_func3[0];
        op1_neg   = is_signed & in_op1[XLEN-1];
        op2_neg   = is_signed & in_op2[XLEN-1];
        div_zero  = (in_op2 == '0);
        div_ovf   = is_signed && (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);
    end

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        func3_d = in_func3;
                        op1_d   = in_op1;
                        op2_d   = in_op2;
                        if (!in_func3[2]) begin
                            state_d = S_MUL;
                        end else if (div_zero) begin
                            res_d   = in_func3[1] ? in_op1 : '1;
                            state_d = S_DONE;
                        end else if (div_ovf) begin
                            res_d   = in_func3[1] ? '0 : in_op1;
                            state_d = S_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = op1_neg ? (~in_op1 + 1'b1) : in_op1;
                            dvs_d   = op2_neg ? (~in_op2 + 1'b1) : in_op2;
                            qneg_d  = op1_neg ^ op2_neg;
                            rneg_d  = op1_neg;
                            cnt_d   = 5'd31;
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    res_d   = mul_res;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    rem_d = rem_new;
                    quo_d = quo_sh;
                    if (cnt_q == 5'd0) begin
                        res_d   = func3_q[1] ? rem_fix : quo_fix;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_DONE: begin
                    if (!out_stall) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            func3_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        mul_valid = (state_q == S_MUL);
        mul_op    = {1'b0, func3_q[1:0]};
        mul_op1   = op1_q;
        mul_op2   = op2_q;
        out_valid = (state_q == S_DONE);
        out_data  = res_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_func3;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic        flush;
    logic        out_stall;
    logic        mul_valid;
    logic [2:0]  mul_op;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [31:0] mul_res;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_func3  (in_func3),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .flush     (flush),
        .out_stall (out_stall),
        .mul_valid (mul_valid),
        .mul_op    (mul_op),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_res   (mul_res),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Combinational multiplier attached to the front-end
    logic [63:0] p_ss, p_su, p_uu;
    always_comb begin
        p_ss = {{32{mul_op1[31]}}, mul_op1} * {{32{mul_op2[31]}}, mul_op2};
        p_su = {{32{mul_op1[31]}}, mul_op1} * {32'b0, mul_op2};
        p_uu = {32'b0, mul_op1} * {32'b0, mul_op2};
        case (mul_op)
            3'd0:    mul_res = p_ss[31:0];
            3'd1:    mul_res = p_ss[63:32];
            3'd2:    mul_res = p_su[63:32];
            default: mul_res = p_uu[63:32];
        endcase
    end

    function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, prod;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin prod = sa * sb; return prod[31:0]; end
            3'd1: begin prod = sa * sb; return prod[63:32]; end
            3'd2: begin prod = sa * ub; return prod[63:32]; end
            3'd3: begin prod = ua * ub; return prod[63:32]; end
            default: begin
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                ia = $signed(a);
                ib = $signed(b);
                case (f3)
                    3'd4:    return 32'(ia / ib);
                    3'd5:    return a / b;
                    3'd6:    return 32'(ia % ib);
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a clock edge with the block idle.
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input logic [31:0] exp, input int lat);
        int cyc;
        check({nm, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_func3  = f3;
        in_op1    = a;
        in_op2    = b;
        out_stall = (stall > 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op1   = $urandom;
        in_op2   = $urandom;
        cyc = 1;
        if (!f3[2]) begin
            check({nm, " mul_valid"}, 32'(mul_valid), 32'd1);
            check({nm, " mul_op"}, 32'(mul_op), 32'(f3));
            check({nm, " mul_op1"}, mul_op1, a);
            check({nm, " mul_op2"}, mul_op2, b);
        end
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, 32'(cyc), 32'(lat));
        check({nm, " data"}, out_data, exp);
        for (int i = 1; i < stall; i++) begin
            @(posedge clk); #1;
            check({nm, " stall valid"}, 32'(out_valid), 32'd1);
            check({nm, " stall data"}, out_data, exp);
            check({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        out_stall = 1'b0;
        @(posedge clk); #1;
        check({nm, " post out_valid"}, 32'(out_valid), 32'd0);
        check({nm, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        check({nm, " out_valid"}, 32'(out_valid), 32'd0);
        check({nm, " out_data"}, out_data, 32'd0);
        check({nm, " mul_valid"}, 32'(mul_valid), 32'd0);
        check({nm, " mul_op"}, 32'(mul_op), 32'd0);
        check({nm, " mul_op1"}, mul_op1, 32'd0);
        check({nm, " mul_op2"}, mul_op2, 32'd0);
        check({nm, " busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_func3  = 3'd0;
        in_op1    = '0;
        in_op2    = '0;
        flush     = 1'b0;
        out_stall = 1'b0;

        vecs.push_back('{"MULH -1*2",      3'd1, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 2});
        vecs.push_back('{"MUL 3*5",        3'd0, 32'd3,         32'd5,        32'd15,        2});
        vecs.push_back('{"MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{"MULHSU -1*2",    3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 2});
        vecs.push_back('{"DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33});
        vecs.push_back('{"REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33});
        vecs.push_back('{"DIVU 100/7",     3'd5, 32'd100,       32'd7,        32'd14,        33});
        vecs.push_back('{"REMU 100/7",     3'd7, 32'd100,       32'd7,        32'd2,         33});
        vecs.push_back('{"DIVU by 0",      3'd5, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 1});
        vecs.push_back('{"REMU by 0",      3'd7, 32'h1234_5678, 32'd0,        32'h1234_5678, 1});
        vecs.push_back('{"DIV overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"REM overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{"REM 5 by 0",     3'd6, 32'd5,         32'd0,        32'd5,         1});
        vecs.push_back('{"DIVU 8000/ffff", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
        vecs.push_back('{"REMU 8000/ffff", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{"DIV 7/-2",       3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});

        #12;
        check_reset_outputs("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].nm, vecs[i].f3, vecs[i].a, vecs[i].b, 0, vecs[i].exp, vecs[i].lat);

        // Result held across a 5-cycle writeback stall
        do_op("DIV stalled", 3'd4, 32'hFFFF_FFF9, 32'd2, 5, 32'hFFFF_FFFD, 33);

        // Flush at DIV iteration 10
        in_valid = 1'b1; in_func3 = 3'd5; in_op1 = 32'd1000; in_op2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("flush busy before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy after", 32'(busy), 32'd0);
        check("flush in_ready after", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no out_valid", 32'(seen), 32'd0);
        do_op("after flush", 3'd4, 32'hFFFF_FF9C, 32'd7, 0, 32'hFFFF_FFF2, 33);

        // in_valid coinciding with flush is dropped
        in_valid = 1'b1; flush = 1'b1; in_func3 = 3'd0; in_op1 = 32'd2; in_op2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush+valid busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush+valid no out_valid", 32'(seen), 32'd0);

        // Asynchronous reset mid-DIV
        in_valid = 1'b1; in_func3 = 3'd4; in_op1 = 32'h0ABC_DEF0; in_op2 = 32'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid-DIV busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check("after reset in_ready", 32'(in_ready), 32'd1);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 20));
            else if (sel == 3) b = -32'($urandom_range(1, 20));
            do_op($sformatf("rand%0d f3=%0d", n, f3), f3, a, b, $urandom_range(0, 3),
                  ref_data(f3, a, b), ref_lat(f3, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencing front-end for the M-extension unit, sitting between the execute stage and the combinational multiplier. Accepts one M-op at a time with a valid/ready handshake and latches its operands. Multiply ops (func3 0-3) go to the multiplier and the result is registered. Divide ops (func3 4-7) run on an internal radix-2 restoring divider, and every result is held until writeback is not stalled.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  core clock
- rstn  input  1  reset; asynchronous, active-low
- in_valid  input  1  execute stage presents an M-op
- in_ready  output  1  block can accept an op this cycle
- in_func3  input  3  RISC-V func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_op1  input  32  rs1 value
- in_op2  input  32  rs2 value
- flush  input  1  pipeline kill; aborts any in-flight op
- out_stall  input  1  writeback stall; result must be held
- mul_valid  output  1  to multiplier: operands valid
- mul_op  output  3  to multiplier: func3 (0-3 only)
- mul_op1  output  32  to multiplier: latched rs1
- mul_op2  output  32  to multiplier: latched rs2
- mul_res  input  32  from multiplier: selected product half
- out_valid  output  1  result available
- out_data  output  32  result
- busy  output  1  op in flight (state != IDLE)

## Operation
- State machine: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid and not flush: latch func3/op1/op2.
  - func3[2]=0 goes to MUL.
  - func3[2]=1 with op2==0 or signed overflow goes to DONE with the special result.
  - Otherwise goes to DIV with counter=31.
- MUL:
  - mul_valid=1; mul_op/op1/op2 driven from the latches.
  - mul_res registered into the result register; go to DONE.
- DIV: one quotient bit per cycle.
  - Remainder register 33 bits, quotient shift register 32 bits.
  - Works on magnitudes: |op1| and |op2| for DIV/REM, raw values for DIVU/REMU.
  - Each cycle: rem = {rem[31:0], dvd[31]}; if rem >= divisor, subtract and shift 1 into the quotient, else shift 0. Counter decrements.
  - At counter 0, sign fix-up is applied in the same cycle, then go to DONE:
    - quotient negated if op1 sign != op2 sign (signed ops);
    - remainder negated if op1 negative (signed ops).
- DONE:
  - out_valid=1, out_data = result register.
  - If !out_stall, go to IDLE next cycle (transfer complete).
  - If out_stall, hold valid and data.
- Special results (RISC-V spec):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- flush: in any state, the next state is IDLE. No out_valid is produced for the aborted op. An in_valid in the same cycle as flush is ignored.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, mul_valid=0, mul_op=0, mul_op1=0, mul_op2=0, busy=0, counter=0.

## Timing
- Cycle 0 is the accept edge (in_valid & in_ready).
- MUL: mul_valid in cycle 1; out_valid in cycle 2. Latency 2.
- Divide by zero or overflow: out_valid in cycle 1. Latency 1.
- Normal DIV: cycles 1-32 iterate; out_valid in cycle 33. Latency 33.
- in_ready is 0 from cycle 1 until the cycle after the DONE transfer. No back-to-back accept in the transfer cycle; one-cycle bubble minimum.
- out_data is stable while out_valid=1 and out_stall=1.
- The multiplier is combinational. mul_res is sampled only at the end of the MUL cycle.

## Test plan
- MULH, op1=0xFFFFFFFF (-1), op2=2 -> mul_op=1 in cycle 1; with the multiplier attached, out_data=0xFFFFFFFF in cycle 2.
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> out_data=0xFFFFFFFD (-3) at cycle 33. REM with the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU -> 2.
- DIVU op1=0x12345678, op2=0 -> out_valid at cycle 1, data 0xFFFFFFFF. REMU -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIV completes while out_stall=1 for 5 cycles -> out_valid and out_data held, in_ready=0. After the stall drops, IDLE next cycle.
- flush asserted at DIV iteration 10 -> IDLE next cycle, no out_valid. An op accepted immediately after gives a correct result.
- rstn asserted mid-DIV (asynchronous) -> all outputs at their reset values immediately. After release, in_ready=1.
